// File: rtl/mem_ctrl_pkg.sv
// Shared defines for the byte-serial memory controller.
// Holds the load/store access-type encodings, the access-size decode, the
// controller FSM state enum and the IO-space address compare.
// No ports (package).
package mem_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        LS_LB  = 3'b000,
        LS_LH  = 3'b001,
        LS_LW  = 3'b010,
        LS_LBU = 3'b011,
        LS_LHU = 3'b100,
        LS_SB  = 3'b101,
        LS_SH  = 3'b110,
        LS_SW  = 3'b111
    } ls_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    function automatic logic is_store(input logic [2:0] t);
        return t[2] && (t[1:0] != 2'b00);
    endfunction

    // Number of bus bytes moved by one access of type t.
    function automatic logic [CNT_W-1:0] size_of(input logic [2:0] t);
        case (t)
            LS_LB, LS_LBU, LS_SB: return 3'd1;
            LS_LH, LS_LHU, LS_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [WORD_W-1:0] a);
        return a[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Load-data lane assembly and extension for mem_ctrl.
// Merges the byte arriving from the bus into its lane of the partially
// assembled word and extends the merged word according to the access type.
// Ports:
//   lanes   in  32 : bytes captured so far
//   din     in  8  : byte currently on the bus
//   lane    in  2  : lane the incoming byte belongs to
//   ls_type in  3  : access type (fetches are presented as LW)
//   merged  out 32 : lanes with the incoming byte inserted
//   result  out 32 : merged word, sign/zero extended for B/H loads
module mem_byte_assembler
    import mem_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] lanes,
    input  logic [BYTE_W-1:0] din,
    input  logic [1:0]        lane,
    input  logic [2:0]        ls_type,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        merged = lanes;
        case (lane)
            2'd0:    merged[7:0]   = din;
            2'd1:    merged[15:8]  = din;
            2'd2:    merged[23:16] = din;
            default: merged[31:24] = din;
        endcase
    end

    always_comb begin
        case (ls_type)
            LS_LB:   result = {{24{merged[7]}}, merged[7:0]};
            LS_LH:   result = {{16{merged[15]}}, merged[15:0]};
            LS_LBU:  result = {24'd0, merged[7:0]};
            LS_LHU:  result = {16'd0, merged[15:0]};
            default: result = merged;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves one 1/2/4-byte LSB access or one
// instruction fetch at a time over the 8-bit RAM/IO bus, LSB first.
// Optional feature macro: MEMCTRL_IO_STALL_EN -- when defined, writes to IO
// space stall while io_buffer_full is high; otherwise io_buffer_full is ignored.
// Ports:
//   clk, rst (async, active high), rdy (global enable), clear (flush)
//   ls_valid/ls_type/ls_addr/ls_wdata  -> ls_done/ls_data   (load/store port)
//   if_valid/if_addr                   -> if_done/if_inst   (fetch port)
//   mem_din in, mem_dout/mem_a/mem_wr out (RAM/IO bus), io_buffer_full in
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        ls_valid,
    input  logic [2:0]  ls_type,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_data,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    import mem_ctrl_pkg::*;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  size;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [2:0]        req_type;
    logic              req_fetch;
    logic [WORD_W-1:0] base;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] lanes;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] result;
    logic [1:0]        lane_idx;
    logic              mem_wr_r;
    logic              io_stall;

    assign nxt_cnt  = cnt + 3'd1;
    // In READ, cnt counts cycles since accept; the byte on mem_din belongs
    // to the address driven one cycle earlier, i.e. lane cnt-1.
    assign lane_idx = 2'(cnt - 3'd1);

`ifdef MEMCTRL_IO_STALL_EN
    assign io_stall = (state == ST_WRITE) && is_io(base) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign io_stall = 1'b0;
`endif

    assign mem_wr = mem_wr_r && rdy && !io_stall;

    mem_byte_assembler u_asm (
        .lanes   (lanes),
        .din     (mem_din),
        .lane    (lane_idx),
        .ls_type (req_type),
        .merged  (merged),
        .result  (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            size      <= '0;
            req_type  <= '0;
            req_fetch <= 1'b0;
            base      <= '0;
            wdata     <= '0;
            lanes     <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr_r  <= 1'b0;
            ls_done   <= 1'b0;
            ls_data   <= '0;
            if_done   <= 1'b0;
            if_inst   <= '0;
        end else if (rdy && !io_stall) begin
            ls_done <= 1'b0;
            if_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_wr_r <= 1'b0;
                    cnt      <= '0;
                    lanes    <= '0;
                    // A flush only lets stores through; loads and fetches wait.
                    if (ls_valid && (is_store(ls_type) || !clear)) begin
                        req_type  <= ls_type;
                        req_fetch <= 1'b0;
                        base      <= ls_addr;
                        wdata     <= ls_wdata;
                        size      <= size_of(ls_type);
                        mem_a     <= ls_addr;
                        if (is_store(ls_type)) begin
                            state    <= ST_WRITE;
                            mem_dout <= ls_wdata[7:0];
                            mem_wr_r <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end else if (!ls_valid && if_valid && !if_done && !clear) begin
                        // if_done high means the IF still presents the old pc.
                        req_type  <= LS_LW;
                        req_fetch <= 1'b1;
                        base      <= if_addr;
                        size      <= 3'd4;
                        mem_a     <= if_addr;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (clear) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        if (cnt != 3'd0) lanes <= merged;
                        if (cnt == size) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            if (req_fetch) begin
                                if_done <= 1'b1;
                                if_inst <= merged;
                            end else begin
                                ls_done <= 1'b1;
                                ls_data <= result;
                            end
                        end else begin
                            cnt <= nxt_cnt;
                            if (nxt_cnt < size) mem_a <= base + {29'd0, nxt_cnt};
                        end
                    end
                end
                ST_WRITE: begin
                    if (nxt_cnt < size) begin
                        cnt      <= nxt_cnt;
                        mem_a    <= base + {29'd0, nxt_cnt};
                        mem_dout <= wdata[{nxt_cnt[1:0], 3'b000} +: 8];
                        mem_wr_r <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        mem_wr_r <= 1'b0;
                        ls_done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl. Stimulus pushes expected completions,
// bus writes and bus addresses (with their cycle numbers) into queues; the
// monitor pops and compares whenever the DUT presents them.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        ls_valid = 1'b0;
    logic [2:0]  ls_type = 3'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_data;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_inst;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .ls_valid(ls_valid), .ls_type(ls_type), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_data(ls_data),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one-cycle read latency; the whole system shares rdy.
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram[mem_a[9:0]];
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
        end
    end

    typedef struct { int cyc; logic [31:0] data; bit chk; } done_t;
    typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [31:0] addr; } addr_t;

    done_t ls_q[$];
    done_t if_q[$];
    wr_t   wr_q[$];
    addr_t ad_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (ls_done) begin
                if (ls_q.size() == 0) fail_now("unexpected ls_done");
                else begin
                    done_t e;
                    e = ls_q.pop_front();
                    check("ls_done cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk) check("ls_data", ls_data, e.data);
                end
            end
            if (if_done) begin
                if (if_q.size() == 0) fail_now("unexpected if_done");
                else begin
                    done_t e;
                    e = if_q.pop_front();
                    check("if_done cycle", 32'(cyc), 32'(e.cyc));
                    check("if_inst", if_inst, e.data);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) fail_now("unexpected mem_wr");
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write cycle", 32'(cyc), 32'(w.cyc));
                    check("write addr", mem_a, w.addr);
                    check("write data", {24'd0, mem_dout}, {24'd0, w.data});
                end
            end
            if (ad_q.size() != 0 && ad_q[0].cyc == cyc) begin
                addr_t a;
                a = ad_q.pop_front();
                check("mem_a", mem_a, a.addr);
            end
        end
    end

    // Issue an LSB request in the current cycle; done expected lat cycles later.
    task automatic ls_issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_data, input int lat);
        done_t e;
        ls_valid = 1'b1;
        ls_type  = t;
        ls_addr  = a;
        ls_wdata = wd;
        e.cyc  = cyc + lat;
        e.data = exp_data;
        e.chk  = !is_store(t);
        ls_q.push_back(e);
        if (is_store(t)) begin
            for (int k = 0; k < int'(size_of(t)); k++) begin
                wr_t w;
                w.cyc  = e.cyc - int'(size_of(t)) + k;
                w.addr = a + 32'(k);
                w.data = 8'(wd >> (8 * k));
                wr_q.push_back(w);
            end
        end
    endtask

    task automatic ls_wait();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (ls_done) return;
        end
        fail_now("timeout waiting for ls_done");
    endtask

    task automatic if_issue(input logic [31:0] a, input logic [31:0] exp_inst, input int lat);
        done_t e;
        if_valid = 1'b1;
        if_addr  = a;
        e.cyc  = cyc + lat;
        e.data = exp_inst;
        e.chk  = 1'b1;
        if_q.push_back(e);
    endtask

    task automatic if_wait();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (if_done) return;
        end
        fail_now("timeout waiting for if_done");
    endtask

    task automatic exp_addr(input int c, input logic [31:0] a);
        addr_t x;
        x.cyc = c;
        x.addr = a;
        ad_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
        ram[10'h140] = 8'h13;
        ram[10'h180] = 8'h80;
        ram[10'h182] = 8'h34; ram[10'h183] = 8'h85;
        ram[10'h200] = 8'h11; ram[10'h201] = 8'h22; ram[10'h202] = 8'h5A; ram[10'h203] = 8'h6B;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'h0);
        check("reset ls_done", {31'd0, ls_done}, 32'h0);
        check("reset if_done", {31'd0, if_done}, 32'h0);
        check("reset ls_data", ls_data, 32'h0);
        check("reset if_inst", if_inst, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // LW little-endian assembly and address sequence
        c0 = cyc;
        for (int k = 0; k < 4; k++) exp_addr(c0 + 1 + k, 32'h100 + 32'(k));
        ls_issue(LS_LW, 32'h100, 32'h0, 32'h12345678, 6);
        ls_wait(); ls_valid = 1'b0;
        idle(2);

        // Byte / halfword extension
        ls_issue(LS_LB, 32'h180, 32'h0, 32'hFFFFFF80, 3);  ls_wait(); ls_valid = 1'b0; idle(1);
        ls_issue(LS_LBU, 32'h180, 32'h0, 32'h00000080, 3); ls_wait(); ls_valid = 1'b0; idle(1);
        ls_issue(LS_LH, 32'h182, 32'h0, 32'hFFFF8534, 4);  ls_wait(); ls_valid = 1'b0; idle(1);
        ls_issue(LS_LHU, 32'h182, 32'h0, 32'h00008534, 4); ls_wait(); ls_valid = 1'b0; idle(1);

        // SH leaves neighbouring bytes alone
        ls_issue(LS_SH, 32'h200, 32'h1234ABCD, 32'h0, 3); ls_wait(); ls_valid = 1'b0; idle(1);
        ls_issue(LS_LW, 32'h200, 32'h0, 32'h6B5AABCD, 6); ls_wait(); ls_valid = 1'b0; idle(1);

        // Address wrap at 2^32
        ls_issue(LS_SW, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h0, 5); ls_wait(); ls_valid = 1'b0; idle(1);
        c0 = cyc;
        exp_addr(c0 + 3, 32'h0);
        ls_issue(LS_LW, 32'hFFFFFFFE, 32'h0, 32'hDEADBEEF, 6); ls_wait(); ls_valid = 1'b0; idle(2);

        // LSB beats fetch; fetch taken in the ls_done cycle once ls_valid drops
        c0 = cyc;
        exp_addr(c0 + 7, 32'h140);
        fork
            begin ls_issue(LS_LW, 32'h100, 32'h0, 32'h12345678, 6); ls_wait(); ls_valid = 1'b0; end
            begin if_issue(32'h140, 32'h00000013, 12); if_wait(); if_valid = 1'b0; end
        join
        idle(2);

        // Back-to-back LSB accesses, second issued in the first's done cycle
        ls_issue(LS_LB, 32'h180, 32'h0, 32'hFFFFFF80, 3);
        ls_wait();
        ls_issue(LS_LBU, 32'h180, 32'h0, 32'h00000080, 3);
        ls_wait(); ls_valid = 1'b0;
        idle(2);

        // Flush in cycle 3 of an LW, then a fetch accepted in cycle 4
        c0 = cyc;
        begin
            done_t e;
            ls_valid = 1'b1; ls_type = LS_LW; ls_addr = 32'h100;
            idle(3);
            clear = 1'b1; ls_valid = 1'b0;
            idle(1);
            clear = 1'b0;
            exp_addr(c0 + 5, 32'h140);
            e.cyc = c0 + 10; e.data = 32'h00000013; e.chk = 1'b1;
            if_q.push_back(e);
            if_valid = 1'b1; if_addr = 32'h140;
            if_wait(); if_valid = 1'b0;
        end
        idle(2);

        // Flush in IDLE: load is held off one cycle, store goes through
        clear = 1'b1;
        ls_issue(LS_LB, 32'h180, 32'h0, 32'hFFFFFF80, 4);
        idle(1); clear = 1'b0;
        ls_wait(); ls_valid = 1'b0; idle(1);
        clear = 1'b1;
        ls_issue(LS_SB, 32'h210, 32'h00000077, 32'h0, 2);
        idle(1); clear = 1'b0;
        ls_wait(); ls_valid = 1'b0; idle(2);

        // rdy low for two cycles stretches LW by two
        ls_issue(LS_LW, 32'h100, 32'h0, 32'h12345678, 8);
        idle(2); rdy = 1'b0;
        idle(2); rdy = 1'b1;
        ls_wait(); ls_valid = 1'b0; idle(2);

        // IO store with the UART buffer full for three cycles
        io_buffer_full = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
        ls_issue(LS_SB, 32'h00030000, 32'h000000A5, 32'h0, 5);
`else
        ls_issue(LS_SB, 32'h00030000, 32'h000000A5, 32'h0, 2);
`endif
        fork
            begin ls_wait(); ls_valid = 1'b0; end
            begin idle(4); io_buffer_full = 1'b0; end
        join
        idle(4);

        if (ls_q.size() != 0) fail_now("missing ls_done");
        if (if_q.size() != 0) fail_now("missing if_done");
        if (wr_q.size() != 0) fail_now("missing bus write");
        if (ad_q.size() != 0) fail_now("missing address check");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the load/store buffer and instruction fetch on one side and the 8-bit unified RAM/IO bus on the other. It accepts one 1/2/4-byte access at a time, arbitrates LSB over fetch, assembles or serialises little-endian data, and pulses a one-cycle completion. It sits directly downstream of the load/store buffer, and its `ls_done`/`ls_data` feed the buffer's finish/value inputs.

## Interface
- No parameters. Width constants come from the shared package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable. While low, all state is frozen and `mem_wr` is forced 0.
- `clear` in 1: mispredict flush. Aborts loads and fetches; stores are never aborted.
- `ls_valid` in 1: LSB request, held until `ls_done`.
- `ls_type` in 3: access type (package encoding).
- `ls_addr` in 32: byte address.
- `ls_wdata` in 32: store data, low bytes used.
- `ls_done` out 1: one-cycle completion pulse, load or store.
- `ls_data` out 32: extended load result, valid with `ls_done`.
- `if_valid` in 1: fetch request, held until `if_done`.
- `if_addr` in 32: fetch address.
- `if_done` out 1: one-cycle pulse.
- `if_inst` out 32: fetched word, valid with `if_done`.
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART output buffer full.

## Operation
- Package encoding: LB=000, LH=001, LW=010, LBU=011, LHU=100, SB=101, SH=110, SW=111. Store = `type[2] && type[1:0]!=0`.
- Size: 1 byte for B, 2 for H, 4 for W and fetch.
- FSM states:
  - IDLE → READ on an accepted load or fetch.
  - IDLE → WRITE on an accepted store.
  - READ/WRITE → IDLE after the last byte.
- Arbitration in IDLE, highest priority first:
  - `ls_valid` wins.
  - `if_valid` is served only if `ls_valid` is low.
  - Fetch is ineligible in the cycle `if_done` is high; the IF still holds the stale pc that cycle.
  - LSB is eligible in its own `ls_done` cycle, because the LSB switches entries combinationally.
- Request fields are latched on accept. A 3-bit byte counter drives `mem_a` = base + i.
- READ: byte i is captured into lane i. B/H loads sign-extend from bit 7/15; BU/HU zero-extend. Fetch uses no extension.
- WRITE: `mem_dout` = wdata byte i with `mem_wr`=1.
- Address arithmetic is 32-bit; a carry across a word boundary is legal and wraps at 2^32.
- IO space is `addr[17:16]==2'b11`. The LSB guarantees IO loads are non-speculative.
- `clear`:
  - In READ: return to IDLE next cycle with no done pulse and `mem_wr`=0.
  - In WRITE: ignored.
  - In IDLE: only a store may be accepted that cycle.
  - A done pulse already registered still fires.
- Async reset: IDLE; `mem_a`, `mem_dout`, `ls_data`, `if_inst` = 0; `mem_wr`, `ls_done`, `if_done` = 0; counter = 0.

## Timing
- RAM read latency is 1: the address driven in cycle c has its data on `mem_din` in cycle c+1.
- Outputs `mem_*`, `*_done`, and data are all registered.
- Request seen in IDLE at cycle 0 → addresses driven in cycles 1..n.
- Load/fetch: bytes captured at the end of cycles 2..n+1; done high in cycle n+2. LW/fetch complete at cycle 6, LB at 3.
- Store: writes in cycles 1..n; done high in cycle n+1. SW completes at cycle 5, SB at 2.
- The done cycle is IDLE, so back-to-back LSB accesses have zero bubble.
- `rdy` low in any cycle stretches latency by exactly that many cycles.

## Configuration
- `MEMCTRL_IO_STALL_EN`:
  - Defined: in WRITE with an IO address and `io_buffer_full`=1, hold the counter and drive `mem_wr`=0 until the buffer is not full. The byte is written in the first non-full cycle.
  - Undefined: `io_buffer_full` is ignored (simulation builds).

## Structure
- The shared package (`defines`) holds:
  - the access-type encodings
  - the size decode function
  - the FSM state enum
  - the IO-space address compare
- One sub-module, `mem_byte_assembler`: lane capture plus sign/zero extension, selected by type.

## Test plan
- LW at 0x100, RAM bytes 78,56,34,12 → `ls_done` in cycle 6 with `ls_data`=0x12345678; `mem_a` = 0x100..0x103 in cycles 1–4.
- LB and LBU on byte 0x80 → `ls_data`=0xFFFFFF80 and 0x00000080 respectively; done at cycle 3.
- SH addr 0x200, wdata 0x1234ABCD → `mem_wr`=1 with CD@0x200 (cycle 1) and AB@0x201 (cycle 2); `ls_done` in cycle 3; RAM 0x202 untouched.
- `ls_valid` and `if_valid` both raised in cycle 0 → the LSB access is served first; the fetch is accepted in the `ls_done` cycle only if `ls_valid` has dropped.
- `clear` in cycle 3 of an LW, then a fetch request → no `ls_done`; `mem_wr` stays 0; the fetch is accepted in cycle 4.
- Macro on: SB to 0x30000 with `io_buffer_full`=1 for 3 cycles → `mem_wr` low for those cycles, the single write follows, and `ls_done` arrives 3 cycles later than nominal.
